// File: rtl/lcd_update_sequencer.sv
// HD44780 8-bit bus sequencer: power-up init, then redraws "ESTADO <v>" and a v-wide bar on each change edge.
// Optional LCD_CLEAR_ON_UPDATE_EN prefixes every frame with a clear-display command.
module lcd_update_sequencer #(
    parameter int MAX_VALUE         = 5,
    parameter int POWERUP_CYCLES    = 2000000,
    parameter int EN_HIGH_CYCLES    = 25,
    parameter int CMD_WAIT_CYCLES   = 2500,
    parameter int CLEAR_WAIT_CYCLES = 100000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         change,
    input  logic [$clog2(MAX_VALUE)-1:0] value,
    output logic                         rs,
    output logic                         rw,
    output logic                         enable,
    output logic [7:0]                   data,
    output logic                         busy
);
    localparam int VW   = $clog2(MAX_VALUE);
    localparam int M1   = (POWERUP_CYCLES > EN_HIGH_CYCLES) ? POWERUP_CYCLES : EN_HIGH_CYCLES;
    localparam int M2   = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int WMAX = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(WMAX + 1);
`ifdef LCD_CLEAR_ON_UPDATE_EN
    localparam logic [5:0] FRAME_LAST = 6'd34;
`else
    localparam logic [5:0] FRAME_LAST = 6'd33;
`endif

    typedef enum logic [2:0] {POWERUP, INIT, IDLE, LOAD, SETUP, PULSE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      idx_q, idx_d;
    logic            init_q, init_d;
    logic [VW-1:0]   v_q, v_d;
    logic            pend_q, pend_d;
    logic            change_q, rise_q, rise_d;
    logic            rs_q, rs_d, en_q, en_d, busy_q, busy_d;
    logic [7:0]      data_q, data_d;
    logic [8:0]      cur;
    logic [5:0]      last_idx;
    logic [CW-1:0]   wait_last;

    // Returns {rs, data} for frame position k (0x80 .. line 2 end).
    function automatic logic [8:0] frame_byte(input logic [5:0] k, input logic [VW-1:0] v);
        logic [8:0] b;
        b = {1'b1, 8'h20};
        if (k == 6'd0) begin
            b = {1'b0, 8'h80};
        end else if (k == 6'd17) begin
            b = {1'b0, 8'hC0};
        end else if (k >= 6'd18) begin
            if ((k - 6'd18) < 6'(v)) b = {1'b1, 8'hFF};
        end else begin
            case (k)
                6'd1:    b = {1'b1, 8'h45};
                6'd2:    b = {1'b1, 8'h53};
                6'd3:    b = {1'b1, 8'h54};
                6'd4:    b = {1'b1, 8'h41};
                6'd5:    b = {1'b1, 8'h44};
                6'd6:    b = {1'b1, 8'h4F};
                6'd8:    b = {1'b1, 8'h30 + 8'(v)};
                default: b = {1'b1, 8'h20};
            endcase
        end
        return b;
    endfunction

    always_comb begin
        cur = 9'h000;
        if (init_q) begin
            case (idx_q[1:0])
                2'd0:    cur = 9'h038;
                2'd1:    cur = 9'h00C;
                2'd2:    cur = 9'h006;
                default: cur = 9'h001;
            endcase
        end else begin
`ifdef LCD_CLEAR_ON_UPDATE_EN
            if (idx_q == 6'd0) cur = 9'h001;
            else cur = frame_byte(idx_q - 6'd1, v_q);
`else
            cur = frame_byte(idx_q, v_q);
`endif
        end
        last_idx  = init_q ? 6'd3 : FRAME_LAST;
        wait_last = (!rs_q && data_q == 8'h01) ? CW'(CLEAR_WAIT_CYCLES - 1)
                                               : CW'(CMD_WAIT_CYCLES - 1);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        init_d   = init_q;
        v_d      = v_q;
        pend_d   = pend_q;
        rs_d     = rs_q;
        data_d   = data_q;
        en_d     = en_q;
        busy_d   = busy_q;
        rise_d   = change & ~change_q;
        // An edge seen while not idle is queued, at most once.
        if (rise_q && state_q != IDLE) pend_d = 1'b1;
        case (state_q)
            POWERUP: if (cnt_q == CW'(POWERUP_CYCLES - 1)) begin
                state_d = INIT;
                cnt_d   = '0;
            end
            INIT: begin
                init_d  = 1'b1;
                idx_d   = 6'd0;
                state_d = SETUP;
                cnt_d   = '0;
            end
            IDLE: if (rise_q) begin
                state_d = LOAD;
                busy_d  = 1'b1;
                cnt_d   = '0;
            end
            LOAD: begin
                v_d     = value;
                idx_d   = 6'd0;
                init_d  = 1'b0;
                busy_d  = 1'b1;
                state_d = SETUP;
                cnt_d   = '0;
            end
            SETUP: begin
                rs_d    = cur[8];
                data_d  = cur[7:0];
                en_d    = 1'b1;
                state_d = PULSE;
                cnt_d   = '0;
            end
            PULSE: if (cnt_q == CW'(EN_HIGH_CYCLES - 1)) begin
                en_d    = 1'b0;
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (cnt_q == wait_last) begin
                cnt_d = '0;
                if (idx_q != last_idx) begin
                    idx_d   = idx_q + 6'd1;
                    state_d = SETUP;
                end else if (pend_d) begin
                    pend_d  = 1'b0;
                    init_d  = 1'b0;
                    state_d = LOAD;
                end else begin
                    init_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = POWERUP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= POWERUP;
            cnt_q    <= '0;
            idx_q    <= 6'd0;
            init_q   <= 1'b0;
            v_q      <= '0;
            pend_q   <= 1'b0;
            change_q <= 1'b0;
            rise_q   <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            en_q     <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            init_q   <= init_d;
            v_q      <= v_d;
            pend_q   <= pend_d;
            change_q <= change;
            rise_q   <= rise_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
        end
    end

    assign rs     = rs_q;
    assign rw     = 1'b0;
    assign enable = en_q;
    assign data   = data_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_lcd_update_sequencer.sv
// Directed bench for lcd_update_sequencer: init sequence, frame contents, queued edges, held change, reset abort.
// Honours LCD_CLEAR_ON_UPDATE_EN for the 35-byte frame layout.
module tb_lcd_update_sequencer;
`ifdef LCD_CLEAR_ON_UPDATE_EN
    localparam int FL  = 35;
    localparam int OFF = 1;
`else
    localparam int FL  = 34;
    localparam int OFF = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       change = 1'b0;
    logic [2:0] value = 3'd0;
    logic       rs, rw, enable, busy;
    logic [7:0] data;

    int total = 0;
    int bad   = 0;

    lcd_update_sequencer #(
        .MAX_VALUE(5), .POWERUP_CYCLES(10), .EN_HIGH_CYCLES(2),
        .CMD_WAIT_CYCLES(4), .CLEAR_WAIT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .change(change), .value(value),
        .rs(rs), .rw(rw), .enable(enable), .data(data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Edge counter since reset release: after posedge e it reads e.
    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Pulse recorder: byte {rs,data}, start edge and high width per enable pulse.
    logic [8:0] byt [512];
    int         st [512];
    int         wd [512];
    int         n = 0;
    int         unstable = 0;
    int         falls = 0;
    int         fall_cyc = 0;
    logic       en_p = 1'b0;
    logic       busy_p = 1'b1;
    logic [8:0] hold = 9'h000;
    always @(negedge clk) begin
        if (enable && !en_p && n < 512) begin
            byt[n] = {rs, data};
            st[n]  = cyc;
            wd[n]  = 1;
            hold   = {rs, data};
            n      = n + 1;
        end else if (enable && en_p && n > 0) begin
            wd[n-1] = wd[n-1] + 1;
            if ({rs, data} != hold) unstable = unstable + 1;
        end
        if (busy_p && !busy) begin
            falls    = falls + 1;
            fall_cyc = cyc;
        end
        en_p   = enable;
        busy_p = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c;
        c = 0;
        repeat (5) step();
        while (busy !== 1'b0 && c < budget) begin
            step();
            c++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic pulse_change();
        change = 1'b1;
        step();
        change = 1'b0;
    endtask

    function automatic int bad_widths(input int from, input int to);
        int b;
        b = 0;
        for (int i = from; i < to; i++) if (wd[i] != 2) b++;
        return b;
    endfunction

    logic [8:0] init_exp [4];
    int base, base2, k, f0, cnt;

    initial begin
        init_exp = '{9'h038, 9'h00C, 9'h006, 9'h001};

        // Reset state
        step();
        step();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_data", 32'(data), 32'h00);
        check("rst_rs", 32'(rs), 32'd0);
        check("rst_rw", 32'(rw), 32'd0);

        // Power-up and init: bus set up at edge 11, strobe from edge 12
        reset = 1'b1;
        step();
        check("init_busy", 32'(busy), 32'd1);
        wait_idle("init_done", 400);
        check("init_count", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) check("init_byte", 32'(byt[i]), 32'(init_exp[i]));
        check("init_first_pulse", 32'(st[0]), 32'd12);
        check("init_busy_fall", 32'(fall_cyc), 32'd43);
        check("init_clear_period", 32'(st[3] - st[2]), 32'd7);
        check("init_widths", 32'(bad_widths(0, 4)), 32'd0);

        // Single frame, value=3; value changed mid-frame must not matter
        repeat (3) step();
        base = n;
        value = 3'd3;
        k = cyc + 1;
        pulse_change();
        repeat (15) step();
        value = 3'd0;
        wait_idle("f1_done", 1000);
        check("f1_count", 32'(n - base), 32'(FL));
        check("f1_latency", 32'(st[base]), 32'(k + 3));
`ifdef LCD_CLEAR_ON_UPDATE_EN
        check("f1_clear", 32'(byt[base]), 32'h001);
        check("f1_clear_period", 32'(st[base+1] - st[base]), 32'd11);
`endif
        check("f1_home", 32'(byt[base+OFF]), 32'h080);
        check("f1_E", 32'(byt[base+OFF+1]), 32'h145);
        check("f1_period", 32'(st[base+OFF+2] - st[base+OFF+1]), 32'd7);
        check("f1_digit", 32'(byt[base+OFF+8]), 32'h133);
        check("f1_line2", 32'(byt[base+OFF+17]), 32'h0C0);
        cnt = 0;
        for (int i = 18; i <= 20; i++) if (byt[base+OFF+i] == 9'h1FF) cnt++;
        check("f1_bar", 32'(cnt), 32'd3);
        cnt = 0;
        for (int i = 21; i <= 33; i++) if (byt[base+OFF+i] == 9'h120) cnt++;
        check("f1_blank", 32'(cnt), 32'd13);
        check("f1_widths", 32'(bad_widths(base, n)), 32'd0);

        // Two edges during one frame collapse into one extra frame sampled at its LOAD
        repeat (3) step();
        base = n;
        f0 = falls;
        value = 3'd1;
        pulse_change();
        repeat (30) step();
        pulse_change();
        repeat (30) step();
        pulse_change();
        value = 3'd4;
        wait_idle("f2_done", 1500);
        repeat (20) step();
        check("f2_count", 32'(n - base), 32'(2 * FL));
        check("f2_busy_falls", 32'(falls - f0), 32'd1);
        check("f2_digit_a", 32'(byt[base+OFF+8]), 32'h131);
        check("f2_digit_b", 32'(byt[base+FL+OFF+8]), 32'h134);
        check("f2_bar_b", 32'(byt[base+FL+OFF+21]), 32'h1FF);
        check("f2_after_bar_b", 32'(byt[base+FL+OFF+22]), 32'h120);

        // change held high for 100 cycles
        base = n;
        value = 3'd2;
        change = 1'b1;
        repeat (100) step();
        change = 1'b0;
        wait_idle("held_done", 1000);
        repeat (20) step();
        check("held_count", 32'(n - base), 32'(FL));

        // Reset during byte 10, with an edge queued beforehand
        base = n;
        pulse_change();
        repeat (20) step();
        pulse_change();
        cnt = 0;
        while (n - base < OFF + 11 && cnt < 300) begin
            step();
            cnt++;
        end
        check("abort_reached", 32'(n - base), 32'(OFF + 11));
        check("abort_en_before", 32'(enable), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_enable", 32'(enable), 32'd0);
        check("abort_data", 32'(data), 32'h00);
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_rs", 32'(rs), 32'd0);
        repeat (3) step();
        base2 = n;
        reset = 1'b1;
        wait_idle("reinit_done", 400);
        repeat (30) step();
        check("reinit_count", 32'(n - base2), 32'd4);
        check("reinit_first", 32'(byt[base2]), 32'h038);
        check("reinit_last", 32'(byt[base2+3]), 32'h001);
        check("reinit_start", 32'(st[base2]), 32'd12);
        check("stable_bus", 32'(unstable), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
